// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard and multi-cycle-unit scheduler for the 5-stage RISC-V core.
// Decides, every cycle, which stage registers hold (stall) or are bubbled
// (flush). The sources are:
//   * load-use hazards that forwarding cannot cover;
//   * taken branches/jumps resolved in EX;
//   * the start/done handshake with the shared multiply/divide unit (MDU).
//     The pipeline is frozen around EX while the MDU works.
// It also owns the MDU timeout watchdog.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, StallCycles and FlushCount are live 32-bit wrapping counters.
//   When undefined, both ports are tied to 0 and no counter flops exist.
//
// Parameters:
//   MD_TIMEOUT   cycles from MdStart until MdError is raised (legal 2..255)
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   Rs1D, Rs2D   source registers of the instruction in ID
//   RdE          destination register of the instruction in EX
//   ResultSrcE0  EX instruction is a load
//   PCSrcE       branch/jump taken in EX
//   MdReqE       EX instruction needs the MDU
//   MdDone       MDU result valid (1-cycle pulse)
//   MdStart      MDU launch pulse
//   StallF/D/E   hold the PC / IF-ID / ID-EX registers
//   FlushD/E/M   bubble the IF-ID / ID-EX / EX-MEM registers
//   MdError      sticky MDU timeout flag (cleared only by reset)
//   StallCycles  count of cycles with StallD = 1
//   FlushCount   count of cycles with FlushE = 1
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        MdReqE,
  input  logic        MdDone,
  output logic        MdStart,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdError,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_ERR  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] timeout_cnt, timeout_cnt_next;
  logic       lw_stall;

  // Ungated decisions; the ports below force them to 0 while reset is held.
  logic md_start_c, stall_f_c, stall_d_c, stall_e_c;
  logic flush_d_c, flush_e_c, flush_m_c, md_error_c;

  // A register written as x0 never creates a real dependency.
  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      timeout_cnt <= '0;
    end else begin
      state       <= state_next;
      timeout_cnt <= timeout_cnt_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_next       = state;
    timeout_cnt_next = timeout_cnt;
    md_start_c       = 1'b0;
    stall_f_c        = 1'b0;
    stall_d_c        = 1'b0;
    stall_e_c        = 1'b0;
    flush_d_c        = 1'b0;
    flush_e_c        = 1'b0;
    flush_m_c        = 1'b0;
    md_error_c       = 1'b0;

    unique case (state)
      RUN: begin
        if (MdReqE) begin
          // MDU launch outranks both a (contradictory) load-use and a taken
          // branch: the EX op must stay put until its result comes back.
          md_start_c       = 1'b1;
          stall_f_c        = 1'b1;
          stall_d_c        = 1'b1;
          stall_e_c        = 1'b1;
          flush_m_c        = 1'b1;
          state_next       = MD_WAIT;
          timeout_cnt_next = '0;
        end else begin
          stall_f_c = lw_stall;
          stall_d_c = lw_stall;
          flush_d_c = PCSrcE;
          flush_e_c = lw_stall || PCSrcE;
        end
      end

      MD_WAIT: begin
        timeout_cnt_next = timeout_cnt + 8'd1;
        if (MdDone) begin
          // Release everything so the EX op advances with the MDU result.
          state_next = RUN;
        end else begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          stall_e_c = 1'b1;
          flush_m_c = 1'b1;
          // Comparing the incremented value puts MdError exactly MD_TIMEOUT
          // cycles after MdStart.
          if (timeout_cnt_next == 8'(MD_TIMEOUT - 1)) state_next = MD_ERR;
        end
      end

      MD_ERR: begin
        stall_f_c  = 1'b1;
        stall_d_c  = 1'b1;
        stall_e_c  = 1'b1;
        flush_m_c  = 1'b1;
        md_error_c = 1'b1;
      end

      default: state_next = RUN;
    endcase
  end

  assign MdStart = rst_n && md_start_c;
  assign StallF  = rst_n && stall_f_c;
  assign StallD  = rst_n && stall_d_c;
  assign StallE  = rst_n && stall_e_c;
  assign FlushD  = rst_n && flush_d_c;
  assign FlushE  = rst_n && flush_e_c;
  assign FlushM  = rst_n && flush_m_c;
  assign MdError = rst_n && md_error_c;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, StallD};
      flush_count_q  <= flush_count_q + {31'd0, FlushE};
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Scoreboard bench for hazard_controller. The driver applies one cycle of
// inputs just after each rising edge, evaluates a behavioural model of the
// hazard rules and pushes the expected output word into a queue. A separate
// monitor pops one word on each falling edge and compares it with the DUT.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        ResultSrcE0, PCSrcE, MdReqE, MdDone;
  logic        MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdError;
  logic [31:0] StallCycles, FlushCount;

  always #5 clk = ~clk;

  hazard_controller #(.MD_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .ResultSrcE0(ResultSrcE0),
    .PCSrcE     (PCSrcE),
    .MdReqE     (MdReqE),
    .MdDone     (MdDone),
    .MdStart    (MdStart),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushM     (FlushM),
    .MdError    (MdError),
    .StallCycles(StallCycles),
    .FlushCount (FlushCount)
  );

  // {MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdError,
  //  StallCycles, FlushCount}
  typedef logic [71:0] obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model: is an MDU op outstanding, how many cycles ago did it
  // start, has the watchdog fired, and how many stall/flush cycles so far.
  bit          m_busy, m_err;
  int          m_since;
  logic [31:0] m_stalls, m_flushes;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit ld, input bit br,
                      input bit req, input bit done);
    bit   start, sf, sd, se, fd, fe, fm, er, hazard;
    obs_t e;
    @(posedge clk);
    #1;
    rst_n = rst; Rs1D = rs1; Rs2D = rs2; RdE = rd;
    ResultSrcE0 = ld; PCSrcE = br; MdReqE = req; MdDone = done;
    cyc++;

    {start, sf, sd, se, fd, fe, fm, er} = '0;
    hazard = ld && (rd != 0) && (rs1 == rd || rs2 == rd);
    if (rst) begin
      if (m_err) begin
        {sf, sd, se, fm, er} = '1;
      end else if (m_busy) begin
        if (done) m_busy = 1'b0;
        else begin
          {sf, sd, se, fm} = '1;
          if (m_since == TO - 1) begin
            m_busy = 1'b0;
            m_err  = 1'b1;
          end
        end
        m_since++;
      end else if (req) begin
        {start, sf, sd, se, fm} = '1;
        m_busy  = 1'b1;
        m_since = 1;
      end else begin
        sf = hazard;
        sd = hazard;
        fd = br;
        fe = hazard || br;
      end
    end

`ifdef HAZARD_STATS_EN
    e = {start, sf, sd, se, fd, fe, fm, er, m_stalls, m_flushes};
`else
    e = {start, sf, sd, se, fd, fe, fm, er, 32'd0, 32'd0};
`endif
    exp_q.push_back(e);

    if (!rst) begin
      m_busy = 1'b0; m_err = 1'b0; m_since = 0;
      m_stalls = '0; m_flushes = '0;
    end else begin
      m_stalls  = m_stalls + 32'(sd);
      m_flushes = m_flushes + 32'(fe);
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cycle%0d", cyc),
            {MdStart, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdError,
             StallCycles, FlushCount}, e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; Rs1D = '0; Rs2D = '0; RdE = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MdReqE = 1'b0; MdDone = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_since = 0; m_stalls = '0; m_flushes = '0;
    repeat (2) @(posedge clk);

    // Reset held with busy inputs: everything must read 0.
    step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Two load-use hazards (one via Rs2D, one via Rs1D), each followed by the
    // bubble cycle, then a taken branch.
    step(1'b1, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    // Load to x0 never stalls.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    check("stats_plan", {8'h0, StallCycles, FlushCount}, {8'h0, 32'd2, 32'd3});
`else
    check("stats_plan", {8'h0, StallCycles, FlushCount}, {8'h0, 32'd0, 32'd0});
`endif

    // MDU op with MdDone 3 cycles after MdStart, branch ignored on launch.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // MdReqE together with a load-use: the MDU wins. MdDone on the last
    // legal cycle beats the timeout.
    step(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (TO - 2) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Timeout: no MdDone ever; MdError is sticky until a 1-cycle reset.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (TO + 2) idle(1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with small register indices so hazards are common.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 39) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end
    idle(1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drain", obs_t'(exp_q.size()), obs_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
